// File: rtl/b02_linea_pkg.sv
// b02_linea_pkg: shared states, limits and counter widths for the LINEA transmitter
package b02_linea_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_t;
  localparam int BCD_MAX = 9;
  localparam int CNT_W   = $clog2(8);
  localparam int GAP_W   = 4;
endpackage

// File: rtl/b02_linea_shreg.sv
// b02_linea_shreg: MSB-first load/shift register with a bit down-counter and registered last flag
module b02_linea_shreg
  import b02_linea_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_din,
  output logic               o_msb,
  output logic               o_last
);
  logic [DIGIT_W-1:0] r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  // zeros shift in behind the digit, so the line is low once a frame has drained
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_sh   <= i_din;
      r_cnt  <= CNT_W'(DIGIT_W - 1);
      r_last <= 1'b0;
    end else if (i_shift) begin
      r_sh   <= {r_sh[DIGIT_W-2:0], 1'b0};
      r_cnt  <= r_cnt - CNT_W'(1);
      r_last <= r_cnt == CNT_W'(1);
    end
  assign o_msb  = r_sh[DIGIT_W-1];
  assign o_last = r_last;
endmodule

// File: rtl/b02_linea_tx.sv
// b02_linea_tx: serial digit transmitter for the b02 LINEA line; optional BCD rejection via B02_LINEA_TX_BCD_CHECK_EN
module b02_linea_tx
  import b02_linea_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clock,
  input  logic               RESET_G,
  input  logic               DIN_VALID,
  input  logic [DIGIT_W-1:0] DIN,
  output logic               DIN_READY,
  output logic               LINEA,
  output logic               FRAME,
  output logic               LAST,
  output logic               DONE,
  output logic               ERR
);
  state_t           r_state;
  state_t           w_nxt;
  logic [GAP_W-1:0] r_gap;
  logic             r_frame;
  logic             r_done;
  logic             r_err;
  logic             w_acc;
  logic             w_bad;
  logic             w_msb;
  logic             w_last;
  assign DIN_READY = r_state == IDLE && !RESET_G;
  assign w_acc     = DIN_VALID && DIN_READY;
`ifdef B02_LINEA_TX_BCD_CHECK_EN
  if (DIGIT_W != 4) begin : g_bcd_width
    $error("b02_linea_tx: BCD check needs DIGIT_W == 4");
  end
  assign w_bad = DIN > DIGIT_W'(BCD_MAX);
`else
  assign w_bad = 1'b0;
`endif
  // a rejected digit completes the handshake but never leaves IDLE
  assign w_nxt = r_state == IDLE  ? ((w_acc && !w_bad) ? SHIFT : IDLE) :
                 r_state == SHIFT ? (w_last ? (GAP_CYCLES > 0 ? GAP : IDLE) : SHIFT) :
                 (r_state == GAP && r_gap != '0) ? GAP : IDLE;
  // state, gap countdown and the registered frame/done/err strobes
  always_ff @(posedge clock)
    if (RESET_G) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_gap   <= r_state == SHIFT ? GAP_W'(GAP_CYCLES - 1) : r_state == GAP ? r_gap - GAP_W'(1) : '0;
      r_frame <= w_nxt == SHIFT;
      r_done  <= r_state == SHIFT && w_last;
      r_err   <= w_acc && w_bad;
    end
  b02_linea_shreg #(.DIGIT_W(DIGIT_W)) u_shreg (
    .i_clk  (clock),
    .i_rst  (RESET_G),
    .i_load (w_acc && !w_bad),
    .i_shift(r_state == SHIFT),
    .i_din  (DIN),
    .o_msb  (w_msb),
    .o_last (w_last)
  );
  assign LINEA = w_msb;
  assign LAST  = w_last;
  assign FRAME = r_frame;
  assign DONE  = r_done;
  assign ERR   = r_err;
endmodule

// File: tb/tb_b02_linea_tx.sv
// tb_b02_linea_tx: directed checks of b02_linea_tx with GAP_CYCLES=1 (u_a) and GAP_CYCLES=0 (u_b)
module tb_b02_linea_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va  = 1'b0;
  logic       vb  = 1'b0;
  logic [3:0] da  = 4'd0;
  logic [3:0] db  = 4'd0;
  logic       rdy_a, lin_a, frm_a, lst_a, don_a, err_a;
  logic       rdy_b, lin_b, frm_b, lst_b, don_b, err_b;
  int         n_chk  = 0;
  int         n_pass = 0;
  always #5 clk = ~clk;
  b02_linea_tx u_a (
    .clock(clk), .RESET_G(rst), .DIN_VALID(va), .DIN(da), .DIN_READY(rdy_a),
    .LINEA(lin_a), .FRAME(frm_a), .LAST(lst_a), .DONE(don_a), .ERR(err_a)
  );
  b02_linea_tx #(.DIGIT_W(4), .GAP_CYCLES(0)) u_b (
    .clock(clk), .RESET_G(rst), .DIN_VALID(vb), .DIN(db), .DIN_READY(rdy_b),
    .LINEA(lin_b), .FRAME(frm_b), .LAST(lst_b), .DONE(don_b), .ERR(err_b)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // expected vector order: {ready, linea, frame, last, done, err}
  task automatic obs_a(input string tag, input logic [5:0] e);
    chk(tag, {2'b00, rdy_a, lin_a, frm_a, lst_a, don_a, err_a}, {2'b00, e});
  endtask
  task automatic obs_b(input string tag, input logic [5:0] e);
    chk(tag, {2'b00, rdy_b, lin_b, frm_b, lst_b, don_b, err_b}, {2'b00, e});
  endtask
  // u_a frame starting in cycle T+1; poke offers a digit mid-frame that must be ignored
  task automatic frame_a(input string tag, input logic [3:0] bits, input bit poke);
    for (int i = 0; i < 4; i++) begin
      obs_a(tag, {1'b0, bits[3-i], 1'b1, i == 3, 2'b00});
      if (poke && i == 1) begin va = 1'b1; da = 4'hF; end
      if (i == 2) va = 1'b0;
      tick;
    end
    obs_a({tag, "_done"}, 6'b000010);
    tick;
    obs_a({tag, "_rdy"}, 6'b100000);
  endtask
  task automatic frame_b(input string tag, input logic [3:0] bits);
    for (int i = 0; i < 4; i++) begin
      obs_b(tag, {1'b0, bits[3-i], 1'b1, i == 3, 2'b00});
      tick;
    end
    obs_b({tag, "_done"}, 6'b100010);
  endtask
  initial begin
    tick;
    tick;
    obs_a("rst_a", 6'b000000);
    obs_b("rst_b", 6'b000000);
    rst = 1'b0;
    #1;
    obs_a("rdy_a", 6'b100000);
    obs_b("rdy_b", 6'b100000);
    va = 1'b1; da = 4'b1001;
    tick;
    va = 1'b0; da = 4'b0000;
    frame_a("f1001", 4'b1001, 1'b0);
    vb = 1'b1; db = 4'b0110;
    tick;
    db = 4'b0011;
    frame_b("b0110", 4'b0110);
    tick;
    vb = 1'b0;
    frame_b("b0011", 4'b0011);
    tick;
    obs_b("b_idle", 6'b100000);
    va = 1'b1; da = 4'b1000;
    tick;
    va = 1'b0;
    frame_a("f1000", 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      obs_a("no_queue", 6'b100000);
    end
    va = 1'b1; da = 4'b1111;
    tick;
    va = 1'b0;
    obs_a("rm_t1", 6'b011000);
    tick;
    obs_a("rm_t2", 6'b011000);
    rst = 1'b1;
    tick;
    obs_a("rm_t3", 6'b000000);
    rst = 1'b0;
    #1;
    obs_a("rm_rel", 6'b100000);
    for (int i = 0; i < 5; i++) begin
      tick;
      obs_a("rm_nodone", 6'b100000);
    end
    va = 1'b1; da = 4'd12;
    tick;
    va = 1'b0;
`ifdef B02_LINEA_TX_BCD_CHECK_EN
    obs_a("bcd_err", 6'b100001);
    va = 1'b1; da = 4'd9;
    tick;
    va = 1'b0;
    frame_a("f9", 4'b1001, 1'b0);
`else
    frame_a("f12", 4'b1100, 1'b0);
`endif
    tick;
    obs_a("end_idle", 6'b100000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
